// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter: FSM state encodings and
// mux select values.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_burst_counter.sv
// Burst length counter for the arbiter. hit flags that the next increment
// reaches MAX_BURST; CNT_W must be wide enough to represent MAX_BURST.
module mux_sel_arbiter_burst_counter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = ((count_q + CNT_W'(1)) == CNT_W'(MAX_BURST));

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin, burst-limited arbiter steering a 2:1 mux between sources A
// and B. The select output is registered so the mux output never glitches.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic ready_a,
    output logic ready_b,
    output logic s,
    output logic out_valid,
    input  logic out_ready
);

    arb_state_e state_q, state_d;
    logic       s_q, s_d;
    logic       last_q, last_d;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_hit;

    mux_sel_arbiter_burst_counter #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .hit (cnt_hit)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        last_d    = last_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        out_valid = 1'b0;
        ready_a   = 1'b0;
        ready_b   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On contention the source opposite the last grant wins.
                if (req_a && (!req_b || last_q == SEL_B)) begin
                    state_d = ST_GNT_A;
                end else if (req_b) begin
                    state_d = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                out_valid = req_a;
                ready_a   = out_ready;
                if (!req_a) begin
                    cnt_clr = 1'b1;
                    state_d = req_b ? ST_GNT_B : ST_IDLE;
                end else if (out_ready) begin
                    if (cnt_hit) begin
                        cnt_clr = 1'b1;
                        if (req_b) begin
                            state_d = ST_GNT_B;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_GNT_B: begin
                out_valid = req_b;
                ready_b   = out_ready;
                if (!req_b) begin
                    cnt_clr = 1'b1;
                    state_d = req_a ? ST_GNT_A : ST_IDLE;
                end else if (out_ready) begin
                    if (cnt_hit) begin
                        cnt_clr = 1'b1;
                        if (req_a) begin
                            state_d = ST_GNT_A;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Select and last-grant follow the granted state; IDLE holds both.
        if (state_d == ST_GNT_A) begin
            s_d    = SEL_A;
            last_d = SEL_A;
        end else if (state_d == ST_GNT_B) begin
            s_d    = SEL_B;
            last_d = SEL_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= SEL_A;
            last_q  <= SEL_B;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
        end
    end

    assign s = s_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed-vector bench for mux_sel_arbiter (MAX_BURST=4): each vector drives
// one cycle of inputs and checks s, out_valid, ready_a, ready_b.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic req_a;
    logic req_b;
    logic ready_a;
    logic ready_b;
    logic s;
    logic out_valid;
    logic out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(
        .MAX_BURST (4),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .ready_a   (ready_a),
        .ready_b   (ready_b),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then step past the edge.
    task automatic vec(input string tag, input logic r, input logic a, input logic b,
                       input logic rdy, input logic es, input logic ev,
                       input logic era, input logic erb);
        rst       = r;
        req_a     = a;
        req_b     = b;
        out_ready = rdy;
        #1;
        $display("%0t %s rst=%b a=%b b=%b rdy=%b -> s=%b v=%b ra=%b rb=%b",
                 $time, tag, r, a, b, rdy, s, out_valid, ready_a, ready_b);
        check({tag, ".s"},       {7'd0, s},         {7'd0, es});
        check({tag, ".valid"},   {7'd0, out_valid}, {7'd0, ev});
        check({tag, ".ready_a"}, {7'd0, ready_a},   {7'd0, era});
        check({tag, ".ready_b"}, {7'd0, ready_b},   {7'd0, erb});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_a     = 1'b1;
        req_b     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with both requesting, then A wins the first contention.
        vec("rst0", 1, 1, 1, 1, 0, 0, 0, 0);
        vec("rst1", 1, 1, 1, 1, 0, 0, 0, 0);
        vec("rel",  0, 1, 1, 1, 0, 0, 0, 0);

        // Contention: 4 A, 4 B, 4 A with no gap.
        for (int i = 0; i < 4; i++) vec("cont_a1", 0, 1, 1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) vec("cont_b",  0, 1, 1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) vec("cont_a2", 0, 1, 1, 1, 0, 1, 1, 0);

        // Two B transfers, then reset mid-burst.
        vec("midb0",  0, 1, 1, 1, 1, 1, 0, 1);
        vec("midb1",  0, 1, 1, 1, 1, 1, 0, 1);
        vec("midrst", 1, 1, 1, 1, 1, 1, 0, 1);
        vec("postrst", 0, 0, 0, 1, 0, 0, 0, 0);
        vec("both_ret", 0, 1, 1, 1, 0, 0, 0, 0);
        vec("a_first",  0, 1, 1, 1, 0, 1, 1, 0);

        // Backpressure in GRANT_A with B waiting: no switch, count frozen at 1.
        for (int i = 0; i < 5; i++) vec("bp", 0, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) vec("bp_rest", 0, 1, 1, 1, 0, 1, 1, 0);
        vec("bp_sw", 0, 1, 1, 1, 1, 1, 0, 1);

        // B drops with A idle: back to IDLE, s holds.
        vec("b_drop", 0, 0, 0, 1, 1, 0, 0, 1);

        // Single source B, 3 items.
        vec("sb_req", 0, 0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) vec("sb_xfer", 0, 0, 1, 1, 1, 1, 0, 1);
        vec("sb_end",  0, 0, 0, 1, 1, 0, 0, 1);
        vec("sb_idle", 0, 0, 0, 1, 1, 0, 0, 0);

        // A alone for 10 items: stays granted, count wraps twice.
        vec("la_req", 0, 1, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) vec("la_xfer", 0, 1, 0, 1, 0, 1, 1, 0);
        // Count is now 2: two more A transfers before B takes over.
        vec("la_c2", 0, 1, 1, 1, 0, 1, 1, 0);
        vec("la_c3", 0, 1, 1, 1, 0, 1, 1, 0);
        vec("la_sw", 0, 1, 1, 1, 1, 1, 0, 1);

        // B drops while A requests: direct switch to A, then A drops to IDLE.
        vec("drop_sw", 0, 1, 0, 1, 1, 0, 0, 1);
        vec("to_a",    0, 1, 0, 1, 0, 1, 1, 0);
        vec("a_drop",  0, 0, 0, 1, 0, 0, 1, 0);
        vec("idle",    0, 0, 0, 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
